// File: rtl/resettable_dff_pair.sv
`default_nettype none
// ============================================================================
// Module      : resettable_dff_pair
// Description : Two D-flop lanes capturing the same data, one cleared by the
//               active-high reset and one by its active-low inverse, with a
//               registered divergence flag and saturating divergence counter.
// Revision    : 1.0 - initial release
// ============================================================================
module resettable_dff_pair #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               CNT_W   = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q_pos,
    output logic [WIDTH-1:0] o_q_neg,
    output logic             o_mismatch,
    output logic [CNT_W-1:0] o_mismatch_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic             w_rstn;
    logic [WIDTH-1:0] r_q_pos;
    logic [WIDTH-1:0] r_q_neg;
    logic             r_mismatch;
    logic [CNT_W-1:0] r_mismatch_cnt;

    assign w_rstn = ~i_rst;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q_pos <= RST_VAL;
        end else begin
            r_q_pos <= i_d;
        end
    end

    // Same capture as the pos lane, but reached through the inverted reset.
    always_ff @(posedge i_clk) begin
        if (!w_rstn) begin
            r_q_neg <= RST_VAL;
        end else begin
            r_q_neg <= i_d;
        end
    end

    // Counter advances on the flag already registered, so it trails it by one edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mismatch     <= 1'b0;
            r_mismatch_cnt <= '0;
        end else begin
            r_mismatch <= (r_q_pos != r_q_neg);
            if (r_mismatch && (r_mismatch_cnt != c_cnt_max)) begin
                r_mismatch_cnt <= r_mismatch_cnt + c_cnt_one;
            end
        end
    end

    assign o_q_pos        = r_q_pos;
    assign o_q_neg        = r_q_neg;
    assign o_mismatch     = r_mismatch;
    assign o_mismatch_cnt = r_mismatch_cnt;

endmodule
`default_nettype wire

// File: tb/tb_resettable_dff_pair.sv
`default_nettype none
// ============================================================================
// Module      : tb_resettable_dff_pair
// Description : Directed plus randomized checks of resettable_dff_pair against
//               a "previous edge: rst ? RST_VAL : d" reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_resettable_dff_pair;

    localparam int          W       = 4;
    localparam logic [W-1:0] RSTV   = '0;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] d   = '0;
    logic [W-1:0] q_pos, q_neg;
    logic         mm;
    logic [7:0]   mm_cnt;

    logic         rst2 = 1'b1;
    logic         d2   = 1'b0;
    logic         q_pos2, q_neg2, mm2;
    logic [1:0]   mm_cnt2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    resettable_dff_pair #(.WIDTH(W), .RST_VAL(RSTV), .CNT_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_d(d),
        .o_q_pos(q_pos), .o_q_neg(q_neg),
        .o_mismatch(mm), .o_mismatch_cnt(mm_cnt)
    );

    resettable_dff_pair #(.WIDTH(1), .RST_VAL(1'b0), .CNT_W(2)) dut2 (
        .i_clk(clk), .i_rst(rst2), .i_d(d2),
        .o_q_pos(q_pos2), .o_q_neg(q_neg2),
        .o_mismatch(mm2), .o_mismatch_cnt(mm_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [W-1:0] exp_q);
        chk({tag, "_pos"}, 32'(q_pos), 32'(exp_q));
        chk({tag, "_neg"}, 32'(q_neg), 32'(exp_q));
        chk({tag, "_mm"},  32'(mm),    32'd0);
        chk({tag, "_cnt"}, 32'(mm_cnt), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one edge's inputs, then check the model value after that edge.
    task automatic cycle(input string tag, input logic r, input logic [W-1:0] dv);
        rst = r;
        d   = dv;
        tick();
        check_all(tag, r ? RSTV : dv);
    endtask

    initial begin
        logic [W-1:0] exp_q;
        logic         r;
        logic [W-1:0] dv;
        int           off;

        // Reset hold with data toggling
        for (int i = 0; i < 4; i++) begin
            cycle("rst_hold", 1'b1, W'($urandom));
        end

        // Capture after release
        cycle("cap0", 1'b0, W'(1));
        cycle("cap1", 1'b0, W'(0));
        cycle("cap2", 1'b0, W'(1));
        cycle("cap3", 1'b0, W'(1));

        // Reset glitch entirely between edges is ignored
        rst = 1'b0;
        d   = W'(1);
        #2 rst = 1'b1;
        #3 rst = 1'b0;
        chk("glitch_mid_pos", 32'(q_pos), 32'd1);
        tick();
        check_all("glitch", W'(1));

        // Reset wins over data on the same edge, next edge captures
        cycle("prio_rst", 1'b1, W'(1));
        cycle("prio_rel", 1'b0, W'(1));

        // Randomized inputs changed at random offsets inside the period
        exp_q = W'(1);
        for (int i = 0; i < 100; i++) begin
            r   = ($urandom_range(0, 3) == 0);
            dv  = W'($urandom);
            off = $urandom_range(0, 6);
            #off;
            rst = r;
            d   = dv;
            if (!r && ($urandom_range(0, 3) == 0)) begin
                #1 rst = 1'b1;
                rst = 1'b0;
            end
            #1;
            chk("rand_hold", 32'(q_pos), 32'(exp_q));
            tick();
            exp_q = r ? RSTV : dv;
            check_all("rand", exp_q);
        end

        // Saturation of a 2-bit counter with lane neg forced apart
        rst2 = 1'b1;
        d2   = 1'b0;
        tick();
        chk("sat_rst_cnt", 32'(mm_cnt2), 32'd0);
        rst2 = 1'b0;
        force dut2.r_q_neg = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("sat_mm",  32'(mm2),     32'd1);
            chk("sat_cnt", 32'(mm_cnt2), 32'((k - 1 > 3) ? 3 : k - 1));
        end
        release dut2.r_q_neg;
        rst2 = 1'b1;
        tick();
        chk("sat_clr_cnt", 32'(mm_cnt2), 32'd0);
        chk("sat_clr_mm",  32'(mm2),     32'd0);
        chk("sat_clr_neg", 32'(q_neg2),  32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/resettable_dff_pair.md
Name: resettable_dff_pair

Overview:
- Paired D flip-flop bank that captures the same data through two reset-polarity paths.
- Lane "pos" is cleared directly by the active-high reset.
- Lane "neg" is cleared by an internally generated active-low reset (rstn = ~i_rst).
- Used as a polarity-equivalence check cell. Both lanes must always agree, and a built-in comparator plus a saturating counter report any divergence.

Parameters:
- WIDTH, 1, data width of each lane.
- RST_VAL, 0, value loaded into both lanes on reset (WIDTH bits, zero-extended).
- CNT_W, 8, width of the mismatch counter.

Ports:
- i_clk  input  1  single clock; all state updates on the rising edge.
- i_rst  input  1  synchronous, active-high reset, sampled on the rising edge of i_clk.
- i_d  input  WIDTH  data input, shared by both lanes.
- o_q_pos  output  WIDTH  lane registered with the active-high reset path.
- o_q_neg  output  WIDTH  lane registered with the internally inverted (active-low) reset path.
- o_mismatch  output  1  registered flag: lanes differed after the previous edge.
- o_mismatch_cnt  output  CNT_W  saturating count of cycles with o_mismatch set.

Behaviour:
- One clock and one reset. Reset is synchronous and active-high (i_rst); no asynchronous paths.
- Internal rstn = ~i_rst. Lane neg evaluates "if (!rstn)"; lane pos evaluates "if (i_rst)". Both are synchronous to the rising edge of i_clk.
- Reset values: o_q_pos = o_q_neg = RST_VAL, o_mismatch = 0, o_mismatch_cnt = 0.
- Capture: on each rising edge with i_rst = 0, o_q_pos <= i_d and o_q_neg <= i_d. Latency is 1 cycle; output holds until the next edge.
- No enable: both lanes capture every non-reset cycle.
- i_d changes between edges have no effect on the outputs until the next rising edge. No combinational path from any input to any output.
- Reset asserted mid-stream: the outputs go to RST_VAL on the first rising edge at which i_rst = 1, not before. A reset pulse that rises and falls entirely between two edges is ignored.
- Reset deassertion: the first edge sampling i_rst = 0 captures the i_d present at that edge.
- Reset and data changing in the same cycle: reset has priority; i_d is discarded on any edge sampling i_rst = 1.
- Comparator: on every edge with i_rst = 0, o_mismatch <= (o_q_pos != o_q_neg), using the current register values.
  - If o_mismatch = 1, o_mismatch_cnt increments by 1, saturating at 2^CNT_W - 1 (no wrap).
  - On a reset edge, o_mismatch and o_mismatch_cnt clear.
- In a correct implementation o_mismatch is never 1. The comparator exists for fault-injection and equivalence checks.
- All outputs are driven directly from flops.

Test Plan:
- Reset hold: hold i_rst = 1 for 4 cycles with i_d toggling -> o_q_pos = o_q_neg = 0, o_mismatch = 0, o_mismatch_cnt = 0 on every edge.
- Capture: release reset, drive i_d = 1,0,1,1 on successive cycles -> each output follows one edge later with values 1,0,1,1; both lanes identical.
- Mid-cycle reset glitch: i_d = 1 captured, then i_rst pulses high for 3 ns between edges (10 ns clock) -> outputs stay 1, no reset.
- Sync reset priority: i_d = 1 with i_rst = 1 at the same edge -> both outputs 0 after that edge. Next edge with i_rst = 0, i_d = 1 -> both outputs 1.
- Random: 100 cycles with i_d and i_rst randomized and changed at random offsets within each 10 ns period -> o_q_pos == o_q_neg always, o_mismatch never set. Scoreboard check: output = previous-edge (i_rst ? RST_VAL : i_d).
- Counter saturation (CNT_W = 2, internal mismatch force of lane neg) -> o_mismatch_cnt counts 1,2,3,3 and clears on the next reset edge.
